multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  7  instruction[6:0] from IR; valid from DECODE until the instruction's last cycle.
REQ-004 br_taken  input  1  datapath comparator result for current branch funct3; sampled in EXEC only.
REQ-005 mem_ready  input  1  memory completes the current request this cycle.
REQ-006 ir_write  output  1  load IR from memory data.
REQ-007 pc_write  output  1  update PC at this edge.
REQ-008 pc_src  output  1  PC source: 0 = PC+4, 1 = live ALU result.
REQ-009 alusrc1  output  1  ALU A select: 0 = A_data, 1 = currentAddress.
REQ-010 alusrc2  output  1  ALU B select: 0 = B_data, 1 = immExt.
REQ-011 alu_op  output  2  00 ADD, 01 compare/SUB, 10 funct-decoded.
REQ-012 jal  output  1  writeback select: 1 = currentAddress+4, 0 = wb_sel path.
REQ-013 wb_sel  output  2  00 immExt, 01 alu_result, 10 memory data.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 mem_read / mem_write  output  1 each  memory request strobes, held until mem_ready.
REQ-016 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-017 illegal  output  1  sticky unsupported-opcode flag.

Function
REQ-018 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRTGT, TRAP; outputs Moore-decoded from state plus opcode; every output not listed for a state SHALL be 0.
REQ-019 IDLE -> FETCH unconditionally.
REQ-020 FETCH: mem_read=1; stay while mem_ready=0; on mem_ready=1 assert ir_write, go DECODE.
REQ-021 DECODE: LUI -> WB; R-type, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, AUIPC -> EXEC; any other opcode -> TRAP.
REQ-022 EXEC controls: R-type alusrc1=0, alusrc2=0, alu_op=10; I-ALU alusrc2=1, alu_op=10; LOAD/STORE alusrc2=1, alu_op=00; AUIPC alusrc1=1, alusrc2=1, alu_op=00; BRANCH alusrc2=0, alu_op=01.
REQ-023 EXEC JAL (alusrc1=1) / JALR (alusrc1=0): alusrc2=1, alu_op=00, reg_write=1, jal=1, pc_write=1, pc_src=1, instr_done=1, -> FETCH.
REQ-024 EXEC BRANCH: br_taken=0 -> pc_write=1, pc_src=0, instr_done=1, -> FETCH; br_taken=1 -> BRTGT.
REQ-025 BRTGT: alusrc1=1, alusrc2=1, alu_op=00, pc_write=1, pc_src=1, instr_done=1, -> FETCH.
REQ-026 EXEC LOAD/STORE -> MEM; all other EXEC cases -> WB.
REQ-027 MEM: ALU address controls of REQ-022 held; LOAD mem_read=1, STORE mem_write=1; stay while mem_ready=0; on mem_ready: LOAD -> WB; STORE pc_write=1, pc_src=0, instr_done=1, -> FETCH.
REQ-028 WB: reg_write=1, pc_write=1, pc_src=0, instr_done=1, jal=0; wb_sel=00 LUI, 10 LOAD, 01 otherwise; -> FETCH.
REQ-029 Latency with mem_ready=1 at first request: LUI/JAL/JALR/not-taken branch 3 cycles; R/I-ALU/AUIPC/STORE/taken branch 4; LOAD 5; each wait cycle adds one.
REQ-030 TRAP: absorbing until reset; illegal=1; all strobes 0.
REQ-031 mem_read and mem_write never simultaneously 1; pc_write at most once per instruction.

Reset
REQ-032 rst_n low asynchronously forces state IDLE and illegal=0; all outputs 0 while in reset and in IDLE.
REQ-033 Reset asserted mid-instruction (including while waiting on mem_ready) aborts it with no further pc_write/reg_write.

Structure
REQ-034 Shared package holds opcode constants, state enumeration, alu_op, wb_sel and pc_src encodings.
REQ-035 One combinational sub-module, rv_op_decode, maps opcode to instruction class and legal flag.

Verification
REQ-036 Release reset, mem_ready=1, opcode=0110011 -> states IDLE,FETCH,DECODE,EXEC,WB; reg_write=1, wb_sel=01 and instr_done=1 only in WB.
REQ-037 LOAD (0000011), mem_ready low 2 cycles in MEM -> mem_read held 3 MEM cycles, WB wb_sel=10, total 7 cycles.
REQ-038 BRANCH (1100011) br_taken=0 -> pc_write with pc_src=0 in EXEC (3 cycles); br_taken=1 -> BRTGT pc_src=1, alusrc1=1, alusrc2=1 (4 cycles).
REQ-039 JAL (1101111) -> EXEC asserts reg_write, jal, pc_write, pc_src=1, alusrc1=1, alusrc2=1 in one cycle.
REQ-040 Opcode 1111111 in DECODE -> TRAP, illegal=1 persists 10 cycles; rst_n pulse clears illegal and returns to IDLE.
REQ-041 rst_n asserted during FETCH wait -> all outputs 0 in the same cycle, restart from IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 control unit.
//   - base opcodes of the supported instruction classes
//   - controller state and instruction-class enumerations
//   - alu_op, wb_sel and pc_src encodings
//   - ctrl_t: bundle of every control output, built in one place by the controller
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_IMM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_ALU   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_BRTGT, ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alusrc1;
        logic       alusrc2;
        logic [1:0] alu_op;
        logic       jal;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle.
//   master: the controller (takes opcode/br_taken/mem_ready, drives controls)
//   slave : the datapath/memory side (drives opcode/br_taken/mem_ready)
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       br_taken;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alusrc1;
    logic       alusrc2;
    logic [1:0] alu_op;
    logic       jal;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, br_taken, mem_ready,
        output ir_write, pc_write, pc_src, alusrc1, alusrc2, alu_op, jal,
               wb_sel, reg_write, mem_read, mem_write, instr_done, illegal
    );

    modport slave (
        output opcode, br_taken, mem_ready,
        input  ir_write, pc_write, pc_src, alusrc1, alusrc2, alu_op, jal,
               wb_sel, reg_write, mem_read, mem_write, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_rv_op_decode.sv
// rv_op_decode: purely combinational opcode classifier.
//   opcode : instruction[6:0]
//   iclass : instruction class (CLS_ILLEGAL for anything unsupported)
//   legal  : 1 when the opcode belongs to a supported class
module rv_op_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        iclass = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE:  iclass = CLS_RTYPE;
            OP_IALU:   iclass = CLS_IALU;
            OP_LOAD:   iclass = CLS_LOAD;
            OP_STORE:  iclass = CLS_STORE;
            OP_BRANCH: iclass = CLS_BRANCH;
            OP_JAL:    iclass = CLS_JAL;
            OP_JALR:   iclass = CLS_JALR;
            OP_LUI:    iclass = CLS_LUI;
            OP_AUIPC:  iclass = CLS_AUIPC;
            default:   iclass = CLS_ILLEGAL;
        endcase
        legal = (iclass != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing a multicycle RV32 datapath.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (state -> IDLE, illegal cleared)
//   bus   : multicycle_ctrl_if.master -- opcode/br_taken/mem_ready in,
//           all datapath and memory control strobes out
// Outputs are decoded from state plus instruction class; the only live
// inputs in the output path are mem_ready (FETCH/MEM completion) and
// br_taken (EXEC of a branch).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_if.master     bus
);

    state_t  state_reg;
    state_t  state_next;
    iclass_t iclass;
    logic    legal;
    ctrl_t   ctrl;

    rv_op_decode u_decode (
        .opcode (bus.opcode),
        .iclass (iclass),
        .legal  (legal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  state_next = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (!legal)                 state_next = ST_TRAP;
                else if (iclass == CLS_LUI) state_next = ST_WB;
                else                        state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (iclass)
                    CLS_JAL, CLS_JALR:   state_next = ST_FETCH;
                    CLS_BRANCH:          state_next = bus.br_taken ? ST_BRTGT : ST_FETCH;
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    default:             state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    state_next = (iclass == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:     state_next = ST_FETCH;
            ST_BRTGT:  state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;   // only reset leaves TRAP
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ctrl = '0;
        case (state_reg)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = bus.mem_ready;
            end
            ST_EXEC: begin
                case (iclass)
                    CLS_RTYPE: ctrl.alu_op = ALU_FUNCT;
                    CLS_IALU: begin
                        ctrl.alusrc2 = 1'b1;
                        ctrl.alu_op  = ALU_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.alusrc2 = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                    end
                    CLS_AUIPC: begin
                        ctrl.alusrc1 = 1'b1;
                        ctrl.alusrc2 = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                    end
                    CLS_BRANCH: begin
                        ctrl.alu_op = ALU_SUB;
                        // Not-taken branch retires here with PC+4.
                        if (!bus.br_taken) begin
                            ctrl.pc_write   = 1'b1;
                            ctrl.pc_src     = PC_PLUS4;
                            ctrl.instr_done = 1'b1;
                        end
                    end
                    CLS_JAL, CLS_JALR: begin
                        // JAL targets PC+imm, JALR targets rs1+imm; both link PC+4.
                        ctrl.alusrc1    = (iclass == CLS_JAL);
                        ctrl.alusrc2    = 1'b1;
                        ctrl.alu_op     = ALU_ADD;
                        ctrl.reg_write  = 1'b1;
                        ctrl.jal        = 1'b1;
                        ctrl.pc_write   = 1'b1;
                        ctrl.pc_src     = PC_ALU;
                        ctrl.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                // Keep the address computation stable for the whole access.
                ctrl.alusrc2 = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                if (iclass == CLS_LOAD) begin
                    ctrl.mem_read = 1'b1;
                end else begin
                    ctrl.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        ctrl.pc_write   = 1'b1;
                        ctrl.pc_src     = PC_PLUS4;
                        ctrl.instr_done = 1'b1;
                    end
                end
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_PLUS4;
                ctrl.instr_done = 1'b1;
                if (iclass == CLS_LUI)       ctrl.wb_sel = WB_IMM;
                else if (iclass == CLS_LOAD) ctrl.wb_sel = WB_MEM;
                else                         ctrl.wb_sel = WB_ALU;
            end
            ST_BRTGT: begin
                ctrl.alusrc1    = 1'b1;
                ctrl.alusrc2    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_ALU;
                ctrl.instr_done = 1'b1;
            end
            ST_TRAP:  ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.ir_write   = ctrl.ir_write;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.alusrc1    = ctrl.alusrc1;
    assign bus.alusrc2    = ctrl.alusrc2;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.jal        = ctrl.jal;
    assign bus.wb_sel     = ctrl.wb_sel;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each cycle step sets mem_ready /
// br_taken, checks the controller state and the full packed output vector
// against hand-derived values, then advances one clock.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    // Output vector layout:
    // [15]ir_write [14]pc_write [13]pc_src [12]alusrc1 [11]alusrc2
    // [10:9]alu_op [8]jal [7:6]wb_sel [5]reg_write [4]mem_read
    // [3]mem_write [2]instr_done [1]illegal [0]0
    localparam logic [15:0] IRW  = 16'h8000;
    localparam logic [15:0] PCW  = 16'h4000;
    localparam logic [15:0] PCS  = 16'h2000;
    localparam logic [15:0] AS1  = 16'h1000;
    localparam logic [15:0] AS2  = 16'h0800;
    localparam logic [15:0] AFN  = 16'h0400;  // alu_op = 10
    localparam logic [15:0] ACMP = 16'h0200;  // alu_op = 01
    localparam logic [15:0] JL   = 16'h0100;
    localparam logic [15:0] WBM  = 16'h0080;  // wb_sel = 10
    localparam logic [15:0] WBA  = 16'h0040;  // wb_sel = 01
    localparam logic [15:0] RW   = 16'h0020;
    localparam logic [15:0] MR   = 16'h0010;
    localparam logic [15:0] MW   = 16'h0008;
    localparam logic [15:0] DONE = 16'h0004;
    localparam logic [15:0] ILL  = 16'h0002;
    localparam logic [15:0] NONE = 16'h0000;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {bus.ir_write, bus.pc_write, bus.pc_src, bus.alusrc1, bus.alusrc2,
                bus.alu_op, bus.jal, bus.wb_sel, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.instr_done, bus.illegal, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One controller cycle: drive inputs, check state and outputs, advance.
    task automatic cyc(input string tag, input state_t st, input logic mr,
                       input logic bt, input logic [15:0] exp);
        bus.mem_ready = mr;
        bus.br_taken  = bt;
        #1;
        chk({tag, "/state"}, 32'(dut.state_reg), 32'(st));
        chk({tag, "/out"}, {16'h0, outs()}, {16'h0, exp});
        chk({tag, "/excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic done_msg(input string name);
        $display("[TB] %s transaction complete at %0t", name, $time);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OP_RTYPE;
        bus.mem_ready = 1'b1;
        bus.br_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/out", {16'h0, outs()}, 32'h0);
        chk("reset/state", 32'(dut.state_reg), 32'(ST_IDLE));
        rst_n = 1'b1;

        // R-type
        cyc("R", ST_IDLE,   1, 0, NONE);
        cyc("R", ST_FETCH,  1, 0, MR | IRW);
        cyc("R", ST_DECODE, 1, 0, NONE);
        cyc("R", ST_EXEC,   1, 0, AFN);
        cyc("R", ST_WB,     1, 0, RW | PCW | DONE | WBA);
        done_msg("R-type");

        // LOAD with two wait cycles in MEM (7 cycles)
        bus.opcode = OP_LOAD;
        cyc("LD", ST_FETCH,  1, 0, MR | IRW);
        cyc("LD", ST_DECODE, 1, 0, NONE);
        cyc("LD", ST_EXEC,   1, 0, AS2);
        cyc("LD", ST_MEM,    0, 0, AS2 | MR);
        cyc("LD", ST_MEM,    0, 0, AS2 | MR);
        cyc("LD", ST_MEM,    1, 0, AS2 | MR);
        cyc("LD", ST_WB,     1, 0, RW | PCW | DONE | WBM);
        done_msg("LOAD");

        // STORE
        bus.opcode = OP_STORE;
        cyc("ST", ST_FETCH,  1, 0, MR | IRW);
        cyc("ST", ST_DECODE, 1, 0, NONE);
        cyc("ST", ST_EXEC,   1, 0, AS2);
        cyc("ST", ST_MEM,    1, 0, AS2 | MW | PCW | DONE);
        done_msg("STORE");

        // Branch not taken (3 cycles)
        bus.opcode = OP_BRANCH;
        cyc("BNT", ST_FETCH,  1, 0, MR | IRW);
        cyc("BNT", ST_DECODE, 1, 0, NONE);
        cyc("BNT", ST_EXEC,   1, 0, ACMP | PCW | DONE);
        done_msg("BRANCH-nt");

        // Branch taken (4 cycles)
        cyc("BT", ST_FETCH,  1, 0, MR | IRW);
        cyc("BT", ST_DECODE, 1, 1, NONE);
        cyc("BT", ST_EXEC,   1, 1, ACMP);
        cyc("BT", ST_BRTGT,  1, 0, AS1 | AS2 | PCW | PCS | DONE);
        done_msg("BRANCH-t");

        // JAL
        bus.opcode = OP_JAL;
        cyc("JAL", ST_FETCH,  1, 0, MR | IRW);
        cyc("JAL", ST_DECODE, 1, 0, NONE);
        cyc("JAL", ST_EXEC,   1, 0, AS1 | AS2 | RW | JL | PCW | PCS | DONE);
        done_msg("JAL");

        // JALR
        bus.opcode = OP_JALR;
        cyc("JALR", ST_FETCH,  1, 0, MR | IRW);
        cyc("JALR", ST_DECODE, 1, 0, NONE);
        cyc("JALR", ST_EXEC,   1, 0, AS2 | RW | JL | PCW | PCS | DONE);
        done_msg("JALR");

        // LUI (3 cycles, wb_sel 00)
        bus.opcode = OP_LUI;
        cyc("LUI", ST_FETCH,  1, 0, MR | IRW);
        cyc("LUI", ST_DECODE, 1, 0, NONE);
        cyc("LUI", ST_WB,     1, 0, RW | PCW | DONE);
        done_msg("LUI");

        // AUIPC
        bus.opcode = OP_AUIPC;
        cyc("AUIPC", ST_FETCH,  1, 0, MR | IRW);
        cyc("AUIPC", ST_DECODE, 1, 0, NONE);
        cyc("AUIPC", ST_EXEC,   1, 0, AS1 | AS2);
        cyc("AUIPC", ST_WB,     1, 0, RW | PCW | DONE | WBA);
        done_msg("AUIPC");

        // I-ALU, with one fetch wait cycle
        bus.opcode = OP_IALU;
        cyc("IALU", ST_FETCH,  0, 0, MR);
        cyc("IALU", ST_FETCH,  1, 0, MR | IRW);
        cyc("IALU", ST_DECODE, 1, 0, NONE);
        cyc("IALU", ST_EXEC,   1, 0, AS2 | AFN);
        cyc("IALU", ST_WB,     1, 0, RW | PCW | DONE | WBA);
        done_msg("I-ALU");

        // Reset during a FETCH wait: outputs drop immediately
        bus.opcode    = OP_RTYPE;
        bus.mem_ready = 1'b0;
        #1;
        chk("rstf/pre_out", {16'h0, outs()}, {16'h0, MR});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstf/out", {16'h0, outs()}, 32'h0);
        chk("rstf/state", 32'(dut.state_reg), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        chk("rstf/hold_out", {16'h0, outs()}, 32'h0);
        rst_n = 1'b1;
        cyc("RST", ST_IDLE,   1, 0, NONE);
        cyc("RST", ST_FETCH,  1, 0, MR | IRW);
        done_msg("reset-in-fetch");

        // Illegal opcode -> TRAP, sticky for 10 cycles, cleared by reset
        bus.opcode = 7'b1111111;
        cyc("ILL", ST_DECODE, 1, 0, NONE);
        for (int i = 0; i < 10; i++) begin
            cyc("ILL", ST_TRAP, 1, 1, ILL);
        end
        rst_n = 1'b0;
        #1;
        chk("illrst/out", {16'h0, outs()}, 32'h0);
        chk("illrst/state", 32'(dut.state_reg), 32'(ST_IDLE));
        #2;
        rst_n = 1'b1;
        #1;
        chk("illrst/illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;
        bus.opcode = OP_LUI;
        cyc("POST", ST_FETCH,  1, 0, MR | IRW);
        cyc("POST", ST_DECODE, 1, 0, NONE);
        cyc("POST", ST_WB,     1, 0, RW | PCW | DONE);
        done_msg("illegal-trap");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
